// File: rtl/ase_umsg_ctrl_if.sv
// UMsg command/stream bundle between the DPI-side command source and the UMsg sequencer.
// master drives commands and the downstream accept; slave is the sequencer.
interface ase_umsg_ctrl_if #(
  parameter int unsigned NUM_UMSG = 8
);
  localparam int unsigned ID_W   = $clog2(NUM_UMSG);
  localparam int unsigned DATA_W = 512;
  localparam int unsigned HDR_W  = 28;
  localparam int unsigned CNT_W  = 16;

  logic                cmd_valid;
  logic [ID_W-1:0]     cmd_id;
  logic [DATA_W-1:0]   cmd_data;
  logic [NUM_UMSG-1:0] hint_en;
  logic                umsg_valid;
  logic                umsg_ready;
  logic [HDR_W-1:0]    umsg_hdr;
  logic [DATA_W-1:0]   umsg_data;
  logic [CNT_W-1:0]    coalesce_cnt;

  modport master (
    output cmd_valid, cmd_id, cmd_data, hint_en, umsg_ready,
    input  umsg_valid, umsg_hdr, umsg_data, coalesce_cnt
  );

  modport slave (
    input  cmd_valid, cmd_id, cmd_data, hint_en, umsg_ready,
    output umsg_valid, umsg_hdr, umsg_data, coalesce_cnt
  );
endinterface

// File: rtl/ase_umsg_ctrl.sv
// Per-AFU UMsg hint/data sequencer: one wait/send state machine per slot, round-robin
// arbitrated onto a single registered UMsg stream for the Rx channel-0 mux.
module ase_umsg_ctrl #(
  parameter int unsigned NUM_UMSG   = 8,
  parameter int unsigned TIMER_W    = 8,
  parameter int unsigned HINT_DELAY = 20,
  parameter int unsigned DATA_DELAY = 40
) (
  input logic              clk,
  input logic              rst_n,
  ase_umsg_ctrl_if.slave   umsg
);
  localparam int unsigned ID_W   = $clog2(NUM_UMSG);
  localparam int unsigned PTR_W  = ID_W + 1;
  localparam int unsigned DATA_W = 512;
  localparam int unsigned HDR_W  = 28;
  localparam int unsigned CNT_W  = 16;
  localparam logic [3:0]  RESP_UMSG = 4'h6;

  typedef enum logic [2:0] {
    UMSG_IDLE,
    HINT_WAIT,
    SEND_HINT,
    DATA_WAIT,
    SEND_DATA
  } slot_state_e;

  slot_state_e        state_q [NUM_UMSG];
  slot_state_e        state_d [NUM_UMSG];
  logic [TIMER_W-1:0] timer_q [NUM_UMSG];
  logic [TIMER_W-1:0] timer_d [NUM_UMSG];
  logic [DATA_W-1:0]  buf_q   [NUM_UMSG];
  logic [DATA_W-1:0]  buf_d   [NUM_UMSG];

  logic               cmd_v_q;
  logic [ID_W-1:0]    cmd_id_q;
  logic [DATA_W-1:0]  cmd_data_q;
  logic               cmd_hint_q;

  logic [ID_W-1:0]    rr_ptr_q;
  logic [CNT_W-1:0]   coalesce_q;
  logic               valid_q;
  logic [HDR_W-1:0]   hdr_q;
  logic [DATA_W-1:0]  data_q;

  logic [NUM_UMSG-1:0] eligible;
  logic [NUM_UMSG-1:0] grant_oh;
  logic                grant_vld;
  logic [ID_W-1:0]     grant_id;
  logic                grant_hint;
  logic                coalesce_inc;
  logic [PTR_W-1:0]    scan_w;
  logic [ID_W-1:0]     scan_id;

  // Command capture stage; hint_en is looked up here so later CSR changes do not matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_v_q    <= 1'b0;
      cmd_id_q   <= '0;
      cmd_data_q <= '0;
      cmd_hint_q <= 1'b0;
    end else begin
      cmd_v_q    <= umsg.cmd_valid;
      cmd_id_q   <= umsg.cmd_id;
      cmd_data_q <= umsg.cmd_data;
      cmd_hint_q <= umsg.hint_en[umsg.cmd_id];
    end
  end

  // Slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_UMSG; i++) begin
        state_q[i] <= UMSG_IDLE;
        timer_q[i] <= '0;
        buf_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_UMSG; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
        buf_q[i]   <= buf_d[i];
      end
    end
  end

  // Round-robin grant: first Send* slot at or after the pointer, only when the output can load.
  always_comb begin
    eligible   = '0;
    grant_oh   = '0;
    grant_vld  = 1'b0;
    grant_id   = '0;
    scan_w     = '0;
    scan_id    = '0;
    for (int i = 0; i < NUM_UMSG; i++) begin
      eligible[i] = (state_q[i] == SEND_HINT) || (state_q[i] == SEND_DATA);
    end
    if (!valid_q || umsg.umsg_ready) begin
      for (int k = 0; k < NUM_UMSG; k++) begin
        scan_w = {1'b0, rr_ptr_q} + PTR_W'(k);
        if (scan_w >= PTR_W'(NUM_UMSG)) begin
          scan_w = scan_w - PTR_W'(NUM_UMSG);
        end
        scan_id = scan_w[ID_W-1:0];
        if (!grant_vld && eligible[scan_id]) begin
          grant_vld = 1'b1;
          grant_id  = scan_id;
        end
      end
    end
    if (grant_vld) begin
      grant_oh[grant_id] = 1'b1;
    end
    grant_hint = (state_q[grant_id] == SEND_HINT);
  end

  // Per-slot next state; a command to a slot finishing SendData this cycle restarts it.
  always_comb begin
    coalesce_inc = 1'b0;
    for (int i = 0; i < NUM_UMSG; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      buf_d[i]   = buf_q[i];
      case (state_q[i])
        HINT_WAIT: begin
          if (timer_q[i] == '0) state_d[i] = SEND_HINT;
          else                  timer_d[i] = timer_q[i] - TIMER_W'(1);
        end
        DATA_WAIT: begin
          if (timer_q[i] == '0) state_d[i] = SEND_DATA;
          else                  timer_d[i] = timer_q[i] - TIMER_W'(1);
        end
        SEND_HINT: begin
          if (grant_oh[i]) begin
            state_d[i] = DATA_WAIT;
            timer_d[i] = TIMER_W'(DATA_DELAY);
          end
        end
        SEND_DATA: begin
          if (grant_oh[i]) state_d[i] = UMSG_IDLE;
        end
        default: ;
      endcase
      if (cmd_v_q && (cmd_id_q == ID_W'(i))) begin
        buf_d[i] = cmd_data_q;
        if ((state_q[i] == UMSG_IDLE) || ((state_q[i] == SEND_DATA) && grant_oh[i])) begin
          state_d[i] = cmd_hint_q ? HINT_WAIT : DATA_WAIT;
          timer_d[i] = cmd_hint_q ? TIMER_W'(HINT_DELAY) : TIMER_W'(DATA_DELAY);
        end else begin
          coalesce_inc = 1'b1;
        end
      end
    end
  end

  // Output stage, pointer and coalesce counter; held while valid && !ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      hdr_q      <= '0;
      data_q     <= '0;
      rr_ptr_q   <= '0;
      coalesce_q <= '0;
    end else begin
      if (grant_vld) begin
        valid_q  <= 1'b1;
        hdr_q    <= {8'h00, RESP_UMSG, grant_hint, 9'h000, 6'(grant_id)};
        data_q   <= grant_hint ? '0 : buf_q[grant_id];
        rr_ptr_q <= (grant_id == ID_W'(NUM_UMSG - 1)) ? '0 : grant_id + ID_W'(1);
      end else if (umsg.umsg_ready) begin
        valid_q  <= 1'b0;
      end
      if (coalesce_inc && (coalesce_q != '1)) begin
        coalesce_q <= coalesce_q + CNT_W'(1);
      end
    end
  end

  assign umsg.umsg_valid   = valid_q;
  assign umsg.umsg_hdr     = hdr_q;
  assign umsg.umsg_data    = data_q;
  assign umsg.coalesce_cnt = coalesce_q;

endmodule

// File: tb/tb_ase_umsg_ctrl.sv
// Directed bench for ase_umsg_ctrl: stimulus pushes expected UMsgs (with arrival cycle)
// into a queue; a negedge monitor pops and compares every accepted UMsg.
module tb_ase_umsg_ctrl;
  localparam int unsigned HD = 20;
  localparam int unsigned DD = 40;

  typedef struct {
    logic [27:0]  hdr;
    logic [511:0] data;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  ase_umsg_ctrl_if #(.NUM_UMSG(8)) ifc ();

  ase_umsg_ctrl #(
    .NUM_UMSG(8), .TIMER_W(8), .HINT_DELAY(HD), .DATA_DELAY(DD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .umsg (ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [27:0] mk_hdr(input logic t, input int id);
    logic [5:0] id6;
    id6 = 6'(id);
    return {8'h00, 4'h6, t, 9'h000, id6};
  endfunction

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic push(input logic t, input int id, input logic [511:0] d, input int c);
    exp_t e;
    e.hdr  = mk_hdr(t, id);
    e.data = d;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // Drives a one-cycle command; k is the cycle it was presented in.
  task automatic send_cmd(input int id, input logic [511:0] d, output int k);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_id    = 3'(id);
    ifc.cmd_data  = d;
    k = cyc;
    tick();
    ifc.cmd_valid = 1'b0;
    ifc.cmd_data  = '0;
  endtask

  task automatic drain(input int max_cyc);
    for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d UMsgs still outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ifc.umsg_valid && ifc.umsg_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_umsg: got hdr=%h at cycle %0d, required none", ifc.umsg_hdr, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("umsg_hdr", 512'(ifc.umsg_hdr), 512'(mon_e.hdr));
        chk("umsg_data", ifc.umsg_data, mon_e.data);
        chk("umsg_cycle", 512'(cyc), 512'(mon_e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, k2, r, nvalid;
    logic [511:0] da, db, dc, dd, dx, dw0, dw3, dw7, dy, dz, dv, de, df;
    da  = {16{32'hA5A5_0002}};
    db  = {16{32'hB0B0_0005}};
    dc  = {16{32'hC1C1_0001}};
    dd  = {16{32'hD1D1_0001}};
    dx  = {16{32'h7777_0001}};
    dw0 = {16{32'h0000_1000}};
    dw3 = {16{32'h3333_1003}};
    dw7 = {16{32'h7777_1007}};
    dy  = {16{32'h7777_2001}};
    dz  = {16{32'h7777_2002}};
    dv  = {16{32'h0000_2000}};
    de  = {16{32'hEEEE_0004}};
    df  = {16{32'hF6F6_0006}};

    ifc.cmd_valid  = 1'b0;
    ifc.cmd_id     = '0;
    ifc.cmd_data   = '0;
    ifc.hint_en    = '0;
    ifc.umsg_ready = 1'b0;
    #2 rst_n = 1'b0;
    tick(); tick(); tick();
    chk("rst_valid", 512'(ifc.umsg_valid), 512'(0));
    chk("rst_hdr", 512'(ifc.umsg_hdr), 512'(0));
    chk("rst_data", ifc.umsg_data, '0);
    chk("rst_coalesce", 512'(ifc.coalesce_cnt), 512'(0));
    rst_n = 1'b1;
    tick(); tick();

    // Data-only path, slot 2.
    ifc.umsg_ready = 1'b1;
    send_cmd(2, da, k);
    push(1'b0, 2, da, k + DD + 4);
    drain(DD + 20);

    // Hint then data, slot 5; hint_en dropped after the command is taken.
    ifc.hint_en = 8'h20;
    send_cmd(5, db, k);
    ifc.hint_en = 8'h00;
    push(1'b1, 5, '0, k + HD + 4);
    push(1'b0, 5, db, k + HD + DD + 6);
    drain(HD + DD + 20);

    // Coalescing into a slot in DataWait: latest data wins.
    send_cmd(1, dc, k);
    wait_until(k + 10);
    send_cmd(1, dd, k2);
    push(1'b0, 1, dd, k + DD + 4);
    drain(DD + 20);
    chk("coalesce_one", 512'(ifc.coalesce_cnt), 512'(1));

    // Slot 7 stalls the output; slots 0,3,7 all queue up behind it.
    ifc.umsg_ready = 1'b0;
    send_cmd(7, dx, k);
    wait_until(k + DD + 6);
    chk("stall_valid", 512'(ifc.umsg_valid), 512'(1));
    send_cmd(0, dw0, k2);
    send_cmd(3, dw3, k2);
    send_cmd(7, dw7, k2);
    wait_until(k2 + DD + 6);
    for (int i = 0; i < 10; i++) begin
      chk("stall_hdr", 512'(ifc.umsg_hdr), 512'(mk_hdr(1'b0, 7)));
      chk("stall_data", ifc.umsg_data, dx);
      tick();
    end
    r = cyc;
    push(1'b0, 7, dx, r);
    push(1'b0, 0, dw0, r + 1);
    push(1'b0, 3, dw3, r + 2);
    push(1'b0, 7, dw7, r + 3);
    ifc.umsg_ready = 1'b1;
    drain(20);

    // Pointer back at 0 with slots 7 and 0 both pending: 0 wins.
    ifc.umsg_ready = 1'b0;
    send_cmd(7, dy, k);
    wait_until(k + DD + 6);
    send_cmd(7, dz, k2);
    send_cmd(0, dv, k2);
    wait_until(k2 + DD + 8);
    r = cyc;
    push(1'b0, 7, dy, r);
    push(1'b0, 0, dv, r + 1);
    push(1'b0, 7, dz, r + 2);
    ifc.umsg_ready = 1'b1;
    drain(20);

    // Reset with a stalled UMsg and a slot in HintWait.
    ifc.umsg_ready = 1'b0;
    send_cmd(1, dc, k);
    wait_until(k + DD + 6);
    chk("pre_rst_valid", 512'(ifc.umsg_valid), 512'(1));
    ifc.hint_en = 8'h10;
    send_cmd(4, de, k2);
    ifc.hint_en = 8'h00;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 512'(ifc.umsg_valid), 512'(0));
    chk("mid_rst_hdr", 512'(ifc.umsg_hdr), 512'(0));
    chk("mid_rst_data", ifc.umsg_data, '0);
    chk("mid_rst_coalesce", 512'(ifc.coalesce_cnt), 512'(0));
    tick(); tick(); tick();
    rst_n = 1'b1;
    ifc.umsg_ready = 1'b1;
    nvalid = 0;
    for (int i = 0; i < HD + DD + 40; i++) begin
      tick();
      if (ifc.umsg_valid) nvalid++;
    end
    chk("post_rst_quiet", 512'(nvalid), 512'(0));
    send_cmd(6, df, k);
    push(1'b0, 6, df, k + DD + 4);
    drain(DD + 20);

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
